asm: RTL and testbench
======================

Name: asm

Overview:
- Algorithmic-state-machine (ASM) block that computes the arithmetic series sum 1+2+...+N for a 32-bit input N.
- Produces the result as a 64-bit value and raises a done flag when finished.
- Standalone compute block started by a pulse on G. Its clock comes from a free-running clock-generator module (simulation only, outside this block's RTL scope).

Parameters:
- NW, 32, width of input N and of the internal down-counter.
- SW, 64, width of the sum output and accumulator.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- N  input  NW  upper bound of the series; sampled only at start.
- G  input  1  go/start request; level input, rising edge detected internally.
- sum  output  SW  accumulator; final result valid while done=1.
- done  output  1  registered completion flag.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Reset (any time, including mid-computation) forces:
  - state=IDLE, sum=0, done=0, counter=0, G-history register=0.
- Start detection:
  - g_prev <= G every clock.
  - start = G & ~g_prev.
  - Holding G high therefore starts only one computation.
- States: IDLE, ADD, DONE. Moore outputs: done=1 only in DONE.
- IDLE:
  - on start: count <= N, sum <= 0, go to ADD.
  - otherwise: hold.
- ADD:
  - if count==0: go to DONE, sum unchanged.
  - else: sum <= sum + count, count <= count - 1, stay in ADD.
  - start is ignored while in ADD.
- DONE:
  - done=1; sum holds N*(N+1)/2.
  - stays in DONE until the next start.
  - on start: count <= N (fresh sample), sum <= 0, go to ADD; done drops on that same edge.
- Latency: done rises on the (N+2)th rising edge after the edge on which start is detected (1 edge load, N edges add, 1 edge detect zero).
- Arithmetic:
  - count is zero-extended to SW before the add.
  - addition is modulo 2^SW. The maximum N=2^32-1 gives about 2^63, so no overflow occurs.
- N=0: result 0; done after 2 edges.
- Changes on N after start have no effect on the running computation.
- sum shows partial values during ADD and must be consumed only while done=1.

Test Plan:
- Reset then N=50; drive G high one cycle after reset release, low 2 cycles later -> done=1 after 52 edges past start; sum=1275; done stays 1, sum stable.
- N=0, single start pulse -> done after 2 edges, sum=0. N=1 -> sum=1. N=10 -> sum=55.
- G held high for 100 cycles with N=5 -> exactly one computation; sum=15; no restart while G stays high.
- Change N from 50 to 7 mid-computation -> result still 1275. A new G rising edge in DONE with N=7 -> done drops, then sum=28.
- Assert rst while in ADD (N=50, after 20 edges) -> sum=0 and done=0 immediately (asynchronous); state IDLE; a subsequent start works normally.
- N=32'hFFFF_FFFF, with counter forced or run to completion -> sum=64'h7FFF_FFFF_8000_0000; no wrap.

Source files
------------

// File: rtl/asm.sv
// Arithmetic series engine: sum = 1 + 2 + ... + N, started by a rising edge on G.
module asm #(
   parameter int unsigned NW = 32,
   parameter int unsigned SW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NW-1:0] N,
   input  logic          G,
   output logic [SW-1:0] sum,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [NW-1:0] count;
   logic [NW-1:0] count_n;
   logic [SW-1:0] sum_n;
   logic          g_prev;
   logic          start_c;

   // Level-to-pulse on G so a held request launches only one computation
   assign start_c = G & ~g_prev;

   // State, datapath and flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         sum    <= '0;
         done   <= 1'b0;
         g_prev <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         sum    <= sum_n;
         done   <= (state_n == DONE);
         g_prev <= G;
      end
   end

   // Next-state and datapath update; N is sampled only on a start
   always_comb begin
      state_n = state;
      count_n = count;
      sum_n   = sum;
      case (state)
         IDLE: begin
            if (start_c) begin
               count_n = N;
               sum_n   = '0;
               state_n = ADD;
            end
         end
         ADD: begin
            if (count == '0) begin
               state_n = DONE;
            end else begin
               sum_n   = sum + SW'(count);
               count_n = count - NW'(1);
            end
         end
         DONE: begin
            if (start_c) begin
               count_n = N;
               sum_n   = '0;
               state_n = ADD;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_asm.sv
// Scoreboarded bench for asm: stimulus pushes expected results, a monitor checks each done.
module tb_asm;

   logic        clk;
   logic        rst;
   logic [31:0] N;
   logic        G;
   logic [63:0] sum;
   logic        done;

   typedef struct {
      logic [63:0] s;
      int          exp_edge;   // -1 skips the latency check
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   logic done_q = 1'b0;

   asm #(.NW(32), .SW(64)) dut (
      .clk  (clk),
      .rst  (rst),
      .N    (N),
      .G    (G),
      .sum  (sum),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter used for latency expectations
   always @(posedge clk) cyc++;

   // Reference model: closed-form series sum
   function automatic logic [63:0] series(input logic [31:0] n);
      logic [63:0] nn;
      nn = {32'd0, n};
      return (nn * (nn + 64'd1)) >> 1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issue a start with G held for 'hold' cycles; queue the expected result
   task automatic start_calc(input logic [31:0] n, input int hold, input bit lat);
      exp_t e;
      @(negedge clk);
      N = n;
      G = 1'b1;
      e.s        = series(n);
      e.exp_edge = lat ? (cyc + 1 + int'(n) + 1) : -1;
      q.push_back(e);
      repeat (hold) @(negedge clk);
      G = 1'b0;
   endtask

   // Bounded wait until every queued result has been seen
   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while ((q.size() != 0 || !done) && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL %s: timeout with %0d results pending, done=%b", name, q.size(), done);
         q.delete();
      end
   endtask

   // Monitor: on each done rising edge pop and compare sum and latency
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            done_q = 1'b0;
         end else begin
            if (done && !done_q) begin
               if (q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_done: done rose at edge %0d with sum %h, nothing expected", cyc, sum);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("result_sum", sum, e.s);
                  if (e.exp_edge >= 0) chk("done_latency", 64'(cyc), 64'(e.exp_edge));
               end
            end
            done_q = done;
         end
      end
   end

   // Global guard against a hung run
   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      logic [31:0] rn;
      rst = 1'b1;
      G   = 1'b0;
      N   = 32'd0;
      #1;
      chk("reset_sum", sum, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // N=50, G high for two cycles
      @(negedge clk);
      start_calc(32'd50, 2, 1'b1);
      wait_idle(80, "n50");
      repeat (5) @(negedge clk);
      chk("n50_hold_done", {63'd0, done}, 64'd1);
      chk("n50_hold_sum", sum, 64'd1275);

      // Small boundary values
      start_calc(32'd0, 1, 1'b1);
      wait_idle(10, "n0");
      start_calc(32'd1, 1, 1'b1);
      wait_idle(10, "n1");
      start_calc(32'd10, 1, 1'b1);
      wait_idle(20, "n10");

      // G held high: exactly one computation
      start_calc(32'd5, 100, 1'b1);
      chk("hold_done", {63'd0, done}, 64'd1);
      chk("hold_sum", sum, 64'd15);
      wait_idle(10, "hold");

      // N changed during computation has no effect
      start_calc(32'd50, 1, 1'b1);
      repeat (10) @(negedge clk);
      N = 32'd7;
      wait_idle(80, "midchange");

      // Restart from DONE with fresh N
      start_calc(32'd7, 1, 1'b1);
      chk("restart_done_drop", {63'd0, done}, 64'd0);
      wait_idle(20, "restart");

      // Asynchronous reset in the middle of ADD
      start_calc(32'd50, 1, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_sum", sum, 64'd0);
      chk("async_rst_done", {63'd0, done}, 64'd0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      start_calc(32'd3, 1, 1'b1);
      wait_idle(20, "after_rst");

      // Maximum N: jump the counter near the end, check full-width result
      start_calc(32'hFFFF_FFFF, 1, 1'b0);
      force dut.count = 32'd3;
      force dut.sum   = 64'h7FFF_FFFF_8000_0000 - 64'd6;
      #1;
      release dut.count;
      release dut.sum;
      wait_idle(20, "nmax");
      chk("nmax_sum_direct", sum, 64'h7FFF_FFFF_8000_0000);

      // Randomized runs, some with N disturbed mid-run
      for (int i = 0; i < 12; i++) begin
         rn = 32'($urandom_range(0, 40));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_calc(rn, int'($urandom_range(1, 3)), 1'b1);
         if ($urandom_range(0, 1) == 1) N = $urandom;
         wait_idle(int'(rn) + 10, "random");
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
